// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed 4-digit hex seven-segment driver with leading-zero blanking and tear-free frame shadowing
module seg7_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] val_i,
  input  logic        en_i,
  input  logic [3:0]  dp_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic {PRIME, SCAN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [15:0] shadow;
  logic [3:0] nib, nz, an_nx;
  logic [6:0] seg_hi, seg_nx;
  logic tick, lit, dp_nx;
  assign tick = cnt == CW'(REFRESH_DIV - 1);
  always_ff @(posedge clk_i) state <= rst_i ? PRIME : state_nx;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
    end else if (state == PRIME) begin
      cnt <= '0;
      idx <= '0;
      shadow <= val_i;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      idx <= tick ? idx + 2'd1 : idx;
      shadow <= (tick && idx == 2'd3) ? val_i : shadow;
    end
  end
  always_comb begin
    state_nx = SCAN;
    nib = shadow[4*idx +: 4];
    case (nib)
      4'h0: seg_hi = 7'h3F;
      4'h1: seg_hi = 7'h06;
      4'h2: seg_hi = 7'h5B;
      4'h3: seg_hi = 7'h4F;
      4'h4: seg_hi = 7'h66;
      4'h5: seg_hi = 7'h6D;
      4'h6: seg_hi = 7'h7D;
      4'h7: seg_hi = 7'h07;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h6F;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h7C;
      4'hC: seg_hi = 7'h39;
      4'hD: seg_hi = 7'h5E;
      4'hE: seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
    // nz[k]: some nibble from k upward is nonzero, so digit k is significant
    nz = {|shadow[15:12], |shadow[15:8], |shadow[15:4], 1'b1};
    lit = state == SCAN && en_i && !(BLANK_LZ && !nz[idx]);
    an_nx = lit ? 4'b0001 << idx : 4'b0000;
    seg_nx = lit ? seg_hi : 7'h00;
    dp_nx = lit && dp_i[idx];
  end
  always_ff @(posedge clk_i) begin
    an_o <= (rst_i ? 4'h0 : an_nx) ^ {4{ACTIVE_LOW}};
    seg_o <= (rst_i ? 7'h00 : seg_nx) ^ {7{ACTIVE_LOW}};
    dp_o <= (rst_i ? 1'b0 : dp_nx) ^ ACTIVE_LOW;
  end
endmodule

// File: doc/seg7_scanner.md
SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clk_i cycles per digit slot, legal values >=2; gives 1 kHz digit rate at 100 MHz.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 drives an_o, seg_o and dp_o active-low.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, rising edge; all logic runs in this domain.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port val_i, input, 16 bits: value to display, typically a counter's cnt_o; nibble k drives digit k, digit 0 rightmost.
REQ-007 SHALL have port en_i, input, 1 bit: display enable, active high.
REQ-008 SHALL have port dp_i, input, 4 bits: decimal point request per digit.
REQ-009 SHALL have port an_o, output, 4 bits: digit anode selects; bit k selects digit k.
REQ-010 SHALL have port seg_o, output, 7 bits: segments, ordered {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp_o, output, 1 bit: decimal point segment.

Function
REQ-012 SHALL contain refresh counter cnt, range 0..REFRESH_DIV-1; tick = (cnt==REFRESH_DIV-1); cnt wraps to 0 on tick.
REQ-013 SHALL contain 2-bit digit index idx, advancing 0->1->2->3->0 on each tick only.
REQ-014 SHALL implement FSM with states PRIME and SCAN: reset enters PRIME; PRIME lasts exactly one cycle, loads shadow<=val_i, then goes to SCAN with idx=0 and cnt=0; SCAN persists until reset.
REQ-015 SHALL, in SCAN, load shadow<=val_i only on a tick with idx==3, so a frame never mixes two values (no tearing).
REQ-016 SHALL decode nibble shadow[4*idx+3:4*idx], active-high form, as: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-017 SHALL, with BLANK_LZ=1, blank digit k (k>=1) when shadow nibbles k..3 are all zero; digit 0 is never blanked.
REQ-018 SHALL, for a blanked digit, en_i low, or FSM state PRIME, drive all anodes, segments and dp inactive.
REQ-019 SHALL, for a lit digit, assert only an_o[idx] and drive seg_o per REQ-016 and dp_o=dp_i[idx].
REQ-020 SHALL register an_o, seg_o and dp_o so all three change on the same edge, one cycle after idx/shadow/en_i change (latency 1).
REQ-021 SHALL apply polarity last: ACTIVE_LOW=1 inverts all active-high values; inactive is then an_o=F, seg_o=7F, dp_o=1.
REQ-022 SHALL keep cnt and idx running while en_i is low; en_i affects outputs only.
REQ-023 SHALL sample dp_i live, not via shadow.

Reset
REQ-024 SHALL, while rst_i is high at a clock edge, set cnt=0, idx=0, shadow=0000, state=PRIME, and drive outputs inactive on that edge.
REQ-025 SHALL let rst_i asserted mid-scan override all other activity, including a coincident tick or shadow load.
REQ-026 SHALL, after rst_i falls, keep outputs inactive for the PRIME cycle and show digit 0 from the second cycle after release.

Verification (REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-027 SHALL cover: BLANK_LZ=0, val_i=1234, en_i=1, release reset -> an_o=E,D,B,7 repeating, 4 cycles each; seg_o=19,30,24,79 (digits 4,3,2,1).
REQ-028 SHALL cover: BLANK_LZ=1, val_i=0050 -> slots 2,3 show an_o=F; slot 1 shows seg_o=12; slot 0 shows seg_o=40. With val_i=0000, only slot 0 is lit.
REQ-029 SHALL cover: val_i changed 1234->ABCD while idx=1 -> slots 2,3 still show 2,1; the next frame shows d,C,b,A, giving seg_o=21,46,03,08.
REQ-030 SHALL cover: en_i dropped during slot 2 -> next cycle an_o=F, seg_o=7F, dp_o=1; on re-enable the display resumes at the correct slot, proving idx kept running.
REQ-031 SHALL cover: rst_i pulsed one cycle at idx=2, cnt=1 -> outputs inactive for the reset and PRIME cycles; idx=0, and slot 0 then lasts a full 4 cycles.
REQ-032 SHALL cover: dp_i=0100 -> dp_o=0 only during slot 2.
